// File: rtl/xalu_ctrl.sv
// xalu_ctrl: multiply/divide sequencer owning HI/LO, with one-edge rollback of the last issued op.
// Optional multiply-accumulate ops (madd/maddu/msub) are built when XALU_MADD_EN is defined.
module xalu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  xop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rollback,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] xalu_out
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q, bhi_q, blo_q;
    logic        pend_q, busy_q;
    logic        is_acc, is_mul, is_div, rb, go, mt, sdiv, wr;
    logic [31:0] ua, ub, uq, ur, dq, dr;
    logic [63:0] pu, ps, res;

`ifdef XALU_MADD_EN
    assign is_acc = xop inside {4'd9, 4'd10, 4'd11};
`else
    assign is_acc = 1'b0;
`endif

    always_comb begin
        is_mul = xop inside {4'd1, 4'd2} || is_acc;
        is_div = xop inside {4'd3, 4'd4};
        rb     = rollback && pend_q;
        go     = start && !busy_q && !rb && (is_mul || is_div);
        mt     = start && !busy_q && !rb && xop inside {4'd7, 4'd8};
        pu     = {32'b0, a_q} * {32'b0, b_q};
        ps     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        // signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly
        sdiv   = op_q == 4'd3;
        ua     = sdiv && a_q[31] ? -a_q : a_q;
        ub     = sdiv && b_q[31] ? -b_q : b_q;
        uq     = ub == 32'd0 ? 32'd0 : ua / ub;
        ur     = ub == 32'd0 ? 32'd0 : ua % ub;
        dq     = sdiv && (a_q[31] ^ b_q[31]) ? -uq : uq;
        dr     = sdiv && a_q[31] ? -ur : ur;
        wr     = !(op_q inside {4'd3, 4'd4} && b_q == 32'd0);
`ifdef XALU_MADD_EN
        res    = op_q == 4'd1 ? ps :
                 op_q == 4'd2 ? pu :
                 op_q inside {4'd3, 4'd4} ? {dr, dq} :
                 op_q == 4'd9 ? {bhi_q, blo_q} + ps :
                 op_q == 4'd10 ? {bhi_q, blo_q} + pu : {bhi_q, blo_q} - ps;
`else
        res    = op_q == 4'd1 ? ps : op_q == 4'd2 ? pu : {dr, dq};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            bhi_q   <= '0;
            blo_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pend_q <= go || mt;
            if (rb) begin
                hi_q    <= bhi_q;
                lo_q    <= blo_q;
                cnt_q   <= '0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (go) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= xop;
                cnt_q   <= is_div ? 8'(DIV_CYC) : 8'(MULT_CYC);
                bhi_q   <= hi_q;
                blo_q   <= lo_q;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else if (mt) begin
                bhi_q <= hi_q;
                blo_q <= lo_q;
                if (xop == 4'd7) hi_q <= a;
                else lo_q <= a;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (wr) {hi_q, lo_q} <= res;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign xalu_out = xop == 4'd5 ? hi_q : xop == 4'd6 ? lo_q : 32'd0;
endmodule

// File: tb/tb_xalu_ctrl.sv
// tb_xalu_ctrl: random and directed ops against a transaction-level HI/LO model.
module tb_xalu_ctrl;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, rollback = 1'b0;
    logic [3:0]  xop = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo, xalu_out;
    logic [31:0] mhi = '0, mlo = '0;
    int total = 0, bad = 0;

    xalu_ctrl dut (.clk(clk), .reset(reset), .start(start), .xop(xop), .a(a), .b(b),
                   .rollback(rollback), .busy(busy), .hi(hi), .lo(lo), .xalu_out(xalu_out));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat(logic [3:0] o);
        if (o inside {4'd1, 4'd2}) return 5;
        if (o inside {4'd3, 4'd4}) return 10;
`ifdef XALU_MADD_EN
        if (o inside {4'd9, 4'd10, 4'd11}) return 5;
`endif
        return 0;
    endfunction

    function automatic logic [63:0] model(logic [3:0] o, logic [31:0] x, logic [31:0] y);
        longint sx = longint'($signed(x)), sy = longint'($signed(y));
        longint unsigned ux = longint'(x), uy = longint'(y);
        longint q, r;
        logic [63:0] cur = {mhi, mlo};
        case (o)
            4'd1: return sx * sy;
            4'd2: return ux * uy;
            4'd3: begin
                if (y == 0) return cur;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            4'd4: return y == 0 ? cur : {x % y, x / y};
            4'd7: return {x, mlo};
            4'd8: return {mhi, y == y ? x : x};
`ifdef XALU_MADD_EN
            4'd9:  return cur + 64'(sx * sy);
            4'd10: return cur + ux * uy;
            4'd11: return cur - 64'(sx * sy);
`endif
            default: return cur;
        endcase
    endfunction

    task automatic do_op(logic [3:0] o, logic [31:0] x, logic [31:0] y, bit rb, bit sd);
        logic [63:0] nxt = model(o, x, y);
        int n = 0;
        start = 1'b1; xop = o; a = x; b = y;
        tick;
        start = 1'b0; xop = 4'd0;
        check("rise", busy, lat(o) > 0);
        if (rb) begin
            rollback = 1'b1;
            if (sd) begin start = 1'b1; xop = 4'd1; a = $urandom; b = $urandom; end
            tick;
            rollback = 1'b0; start = 1'b0; xop = 4'd0;
            check("rb_busy", busy, 0);
            if (sd) begin
                repeat (12) begin tick; if (busy) n++; end
                check("rb_drop", n, 0);
            end
        end else begin
            while (busy && n < 64) begin tick; n++; end
            check("lat", n, lat(o));
            {mhi, mlo} = nxt;
        end
        check("hi", hi, mhi);
        check("lo", lo, mlo);
        xop = 4'd5; #1 check("mfhi", xalu_out, mhi);
        xop = 4'd6; #1 check("mflo", xalu_out, mlo);
        xop = 4'd0;
    endtask

    initial begin
        tick;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_out", xalu_out, 0);
        reset = 1'b1;
        tick;
        do_op(4'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
        check("plan_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        do_op(4'd2, 32'hFFFFFFFE, 32'd3, 0, 0);
        check("plan_multu", {hi, lo}, 64'h00000002_FFFFFFFA);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        check("plan_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd4, 32'h12345678, 32'd0, 0, 0);
        check("plan_div0", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        check("plan_ovf", {hi, lo}, 64'h00000000_80000000);
        do_op(4'd7, 32'h55, 32'd0, 0, 0);
        do_op(4'd7, 32'h1234, 32'd0, 1, 0);
        check("plan_rb_mthi", hi, 32'h55);
        do_op(4'd7, 32'h1234, 32'd0, 0, 0);
        tick;
        rollback = 1'b1;
        tick;
        rollback = 1'b0;
        check("plan_late_rb", hi, 32'h1234);
        do_op(4'd1, 32'h7, 32'h9, 1, 1);
        check("plan_rb_mult", {hi, lo}, {32'h1234, mlo});
        do_op(4'd8, 32'hFFFFFFFF, 32'd0, 0, 0);
        do_op(4'd7, 32'h0, 32'd0, 0, 0);
        do_op(4'd9, 32'd1, 32'd1, 0, 0);
`ifdef XALU_MADD_EN
        check("plan_madd", {hi, lo}, 64'h00000001_00000000);
`else
        check("plan_madd", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif
        for (int i = 0; i < 60; i++) begin
            logic [3:0] o = 4'($urandom_range(0, 15));
            logic [31:0] x = $urandom, y = $urandom;
            bit rb = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) y = {16'd0, y[15:0]} | 32'd1;
            do_op(o, x, y, rb, rb && $urandom_range(0, 1) == 1);
        end
        do_op(4'd7, 32'hDEAD, 32'd0, 0, 0);
        start = 1'b1; xop = 4'd3; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0; xop = 4'd0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hilo", {hi, lo}, 64'd0);
        tick;
        reset = 1'b1;
        repeat (12) tick;
        check("arst_nocommit", {busy, hi, lo}, 65'd0);
        mhi = '0; mlo = '0;
        do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xalu_ctrl.md
# xalu_ctrl

Sequencer for the multi-cycle multiply/divide unit (HI/LO datapath) in the E stage of the pipelined CPU. It accepts one operation per start pulse and owns the HI/LO registers. It drives `busy` for the pause logic for the operation's fixed latency, and commits results at the end of that latency. It also undoes the most recently started operation when the interrupt logic asserts `rollback`.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu (and madd family).
- `DIV_CYC`, default 10: busy cycles for div/divu.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  op issue strobe from E stage; already gated by the interrupt request.
- `xop`  in  4  operation code:
  - 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mfhi; 6 mflo; 7 mthi; 8 mtlo.
  - 9 madd; 10 maddu; 11 msub (these three exist only under `XALU_MADD_EN`).
- `a`  in  32  rs operand (forwarded).
- `b`  in  32  rt operand (forwarded).
- `rollback`  in  1  cancel the operation accepted on the previous edge.
- `busy`  out  1  arithmetic in progress; the pipeline pauses any HI/LO-using instruction in D.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `xalu_out`  out  32  combinational: `hi` when xop=5, `lo` when xop=6, else 0.

## Operation
- States: IDLE, RUN.
- IDLE to RUN:
  - Condition: `start` with xop in {1,2,3,4} (or {9,10,11} when enabled), sampled on an edge.
  - Action: latch `a`, `b` and xop; load the down-counter with `MULT_CYC` or `DIV_CYC`.
  - Action: copy HI/LO into the backup registers.
- RUN: the counter decrements each edge.
  - When the counter reaches 1, the next edge writes the result to HI/LO, clears `busy` and returns to IDLE.
- mthi/mtlo (7/8) with `start`:
  - Copy HI/LO to backup, then write `a` into HI or LO on that edge.
  - No RUN state, no `busy`.
- mfhi/mflo need no `start`. They are pure reads of the current HI/LO; the E-stage pause logic guarantees they never read during RUN.
- Arithmetic rules:
  - mult: signed 32x32 to 64, HI=[63:32], LO=[31:0].
  - multu: unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder carrying the dividend's sign.
  - divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero: the operation runs the full `DIV_CYC` cycles; HI/LO stay unchanged.
- `start` while `busy`=1 is ignored; the pause logic never issues it.
- Rollback:
  - Valid only on the edge directly after an accepted start (a one-cycle `pending` flag).
  - Effect: HI/LO restored from backup, counter cleared, state to IDLE, `busy` low.
  - This covers both arithmetic ops and mthi/mtlo.
  - `rollback` without `pending` is ignored.
- `start` and `rollback` on the same edge: rollback wins; the new start is dropped.
- Unused xop codes (12-15, or 9-11 when disabled) with `start`: no effect.

## Timing
- Reset values:
  - `busy`=0, `hi`=0, `lo`=0, `xalu_out`=0.
  - State IDLE; counter, backup registers and `pending` all cleared.
- `busy` rises on the edge that accepts the start. It stays high for exactly `MULT_CYC` or `DIV_CYC` cycles.
- HI/LO update on the same edge `busy` falls.
- An mfhi in E the cycle after `busy` falls sees the new value.
- Back-to-back ops: a new start is accepted on the first cycle `busy`=0.
- Reset asserted mid-RUN aborts immediately; no commit follows after release.

## Configuration
- `XALU_MADD_EN` defined:
  - xop 9 (madd): {HI,LO} += signed a*b.
  - xop 10 (maddu): {HI,LO} += unsigned a*b.
  - xop 11 (msub): {HI,LO} -= signed a*b.
  - Latency `MULT_CYC`; the accumulation uses the HI/LO value latched at start; rollback restores the backup.
- Undefined: xop 9-11 are treated as unused (no busy, no HI/LO change), and the accumulate adder is not synthesized.

## Test plan
- Reset low mid-RUN of a div, then released -> `busy`=0, hi=lo=0 at once; no commit afterward.
- mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following divu by 0 -> HI/LO unchanged after 10 cycles.
- mthi a=0x1234 with hi=0x55, `rollback` on the next edge -> hi back to 0x55. `rollback` two edges after a start -> ignored, hi=0x1234.
- mult accepted, `rollback` the next cycle -> `busy` low at that edge; HI/LO keep their pre-start values. A `start` presented on the same edge as the rollback is dropped.
- With `XALU_MADD_EN`: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=0x00000001, lo=0x00000000 after 5 cycles. Without the macro, the same stimulus -> `busy` stays 0 and HI/LO are unchanged.
